// File: rtl/aes_mix_columns_iter_if.sv
// Handshake and data bundle for the column-serial MixColumns stage.
// The slave modport is the block's view; master is the producer/consumer side.
interface aes_mix_columns_iter_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic         op_i;
  logic [127:0] data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] data_o;
  logic         busy_o;

  modport slave (
    input  in_valid_i,
    input  op_i,
    input  data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output data_o,
    output busy_o
  );

  modport master (
    output in_valid_i,
    output op_i,
    output data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  data_o,
    input  busy_o
  );
endinterface

// File: rtl/aes_mix_columns_iter.sv
// Iterative MixColumns / InvMixColumns: one column per cycle through a single mixer.
// Optional macro AES_MIX_COLUMNS_ITER_CLEAR_EN adds a synchronous clear_i and gates data_o.
module aes_mix_single_column (
  input  logic        op_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  logic [7:0] a0, a1, a2, a3, u, v, t;

  // Inverse is the forward matrix preceded by a cheap 4*(a0^a2)/4*(a1^a3) pre-mix.
  always_comb begin
    a0 = data_i[7:0];
    a1 = data_i[15:8];
    a2 = data_i[23:16];
    a3 = data_i[31:24];
    u  = xtime(xtime(a0 ^ a2));
    v  = xtime(xtime(a1 ^ a3));
    if (op_i) begin
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
    end
    t = a0 ^ a1 ^ a2 ^ a3;
    data_o[7:0]   = a0 ^ t ^ xtime(a0 ^ a1);
    data_o[15:8]  = a1 ^ t ^ xtime(a1 ^ a2);
    data_o[23:16] = a2 ^ t ^ xtime(a2 ^ a3);
    data_o[31:24] = a3 ^ t ^ xtime(a3 ^ a0);
  end

endmodule

module aes_mix_columns_iter #(
  parameter int NumCols = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef AES_MIX_COLUMNS_ITER_CLEAR_EN
  input  logic clear_i,
`endif
  aes_mix_columns_iter_if.slave bus
);

  if (NumCols != 4) begin : gen_num_cols_check
    $error("aes_mix_columns_iter supports NumCols == 4 only");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic       CiphFwd = 1'b0;
  localparam logic [1:0] LastCol = 2'(NumCols - 1);

  state_e       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] data_q, data_d;
  logic         op_q, op_d;
  logic [31:0]  col_word, mixed_word;
  logic         accept;

  // Gather column col_cnt_q into a word with row 0 in the low byte.
  always_comb begin
    col_word = '0;
    for (int r = 0; r < 4; r++) begin
      col_word[8*r +: 8] = data_q[8*(4*r + int'(col_cnt_q)) +: 8];
    end
  end

  aes_mix_single_column u_mix (
    .op_i   (op_q),
    .data_i (col_word),
    .data_o (mixed_word)
  );

  always_comb begin
    bus.in_ready_o = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready_i);
`ifdef AES_MIX_COLUMNS_ITER_CLEAR_EN
    bus.in_ready_o = bus.in_ready_o && !clear_i;
`endif
  end

  assign accept          = bus.in_ready_o && bus.in_valid_i;
  assign bus.out_valid_o = (state_q == StDone);
  assign bus.busy_o      = (state_q == StBusy);

`ifdef AES_MIX_COLUMNS_ITER_CLEAR_EN
  assign bus.data_o = bus.out_valid_o ? data_q : '0;
`else
  assign bus.data_o = data_q;
`endif

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    data_d    = data_q;
    op_d      = op_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          data_d    = bus.data_i;
          op_d      = bus.op_i;
          col_cnt_d = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        for (int r = 0; r < 4; r++) begin
          data_d[8*(4*r + int'(col_cnt_q)) +: 8] = mixed_word[8*r +: 8];
        end
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == LastCol) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (accept) begin
          data_d    = bus.data_i;
          op_d      = bus.op_i;
          col_cnt_d = '0;
          state_d   = StBusy;
        end else if (bus.out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef AES_MIX_COLUMNS_ITER_CLEAR_EN
    if (clear_i) begin
      state_d   = StIdle;
      col_cnt_d = '0;
      data_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      col_cnt_q <= '0;
      data_q    <= '0;
      op_q      <= CiphFwd;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
      op_q      <= op_d;
    end
  end

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Scoreboard bench for aes_mix_columns_iter; expected states come from a GF(2^8) matrix model.
// Define AES_MIX_COLUMNS_ITER_CLEAR_EN to also exercise clear_i.
module tb_aes_mix_columns_iter;

  logic clk = 1'b0;
  logic rst_n;
`ifdef AES_MIX_COLUMNS_ITER_CLEAR_EN
  logic clear_s;
`endif

  always #5 clk = ~clk;

  aes_mix_columns_iter_if bus ();

  aes_mix_columns_iter dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
`ifdef AES_MIX_COLUMNS_ITER_CLEAR_EN
    .clear_i (clear_s),
`endif
    .bus     (bus.slave)
  );

  int           n_checks = 0;
  int           n_fails  = 0;
  logic [127:0] exp_q[$];
  logic         acc, fire;
  logic [127:0] fire_data;
  logic [127:0] fwd_in, fwd_out;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic op);
    logic [7:0]   coef[4];
    logic [7:0]   a[4];
    logic [7:0]   b;
    logic [127:0] res = '0;
    if (op) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[8*(r*4+c) +: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - r) & 3], a[k]);
        res[8*(r*4+c) +: 8] = b;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] build_state(input logic [31:0] w0, input logic [31:0] w1,
                                               input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0]  w[4];
    logic [127:0] s = '0;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[8*(r*4+c) +: 8] = w[c][8*r +: 8];
    return s;
  endfunction

  // Drive one cycle from edge+1, observe the handshake before the next edge, log accepts.
  task automatic apply_stimulus(input logic v, input logic op, input logic [127:0] d, input logic rdy);
    bus.in_valid_i  = v;
    bus.op_i        = op;
    bus.data_i      = d;
    bus.out_ready_i = rdy;
    #1;
    acc       = v && bus.in_ready_o;
    fire      = bus.out_valid_o && rdy;
    fire_data = bus.data_o;
    if (acc) exp_q.push_back(ref_mix(d, op));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid_i = 1'b0; bus.op_i = 1'b0; bus.data_i = '0; bus.out_ready_i = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready_o); end
    n_checks++;
    if (bus.out_valid_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
    n_checks++;
    if (bus.busy_o !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy_o); end
    n_checks++;
    if (bus.data_o !== 128'h0) begin n_fails++; $display("[TB] FAIL reset_data got %h want 0", bus.data_o); end
    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_fwd_vector();
    logic [127:0] want, e;
    int lat = 0;
    fwd_in  = build_state(32'h455313db, 32'h5c220af2, 32'h01010101, 32'hd5d4d4d4);
    want    = build_state(32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hd6d7d5d5);
    fwd_out = want;
    apply_stimulus(1'b1, 1'b0, fwd_in, 1'b1);
    n_checks++;
    if (acc !== 1'b1) begin n_fails++; $display("[TB] FAIL fwd_accept got %b want 1", acc); end
    while (lat < 20) begin
      apply_stimulus(1'b0, 1'b0, '0, 1'b1);
      if (fire) break;
      lat++;
    end
    n_checks++;
    if (lat !== 4) begin n_fails++; $display("[TB] FAIL fwd_latency got %0d want 4", lat); end
    n_checks++;
    if (fire_data !== want) begin n_fails++; $display("[TB] FAIL fwd_vector got %h want %h", fire_data, want); end
    if (fire && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fire_data !== e) begin n_fails++; $display("[TB] FAIL fwd_model got %h want %h", fire_data, e); end
    end
  endtask

  task automatic test_inverse();
    logic [127:0] e;
    int budget = 0;
    apply_stimulus(1'b1, 1'b1, fwd_out, 1'b1);
    do begin
      apply_stimulus(1'b0, 1'b0, '0, 1'b1);
      budget++;
    end while (!fire && budget < 20);
    n_checks++;
    if (!fire) begin n_fails++; $display("[TB] FAIL inv_timeout got no output want output"); end
    else begin
      n_checks++;
      if (fire_data !== fwd_in) begin n_fails++; $display("[TB] FAIL inv_restore got %h want %h", fire_data, fwd_in); end
      e = exp_q.pop_front();
      n_checks++;
      if (fire_data !== e) begin n_fails++; $display("[TB] FAIL inv_model got %h want %h", fire_data, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] held, e, nxt;
    int budget = 0;
    apply_stimulus(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    while (!bus.out_valid_o && budget < 10) begin
      apply_stimulus(1'b0, 1'b0, '0, 1'b0);
      budget++;
    end
    held = bus.data_o;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.data_o !== held || bus.in_ready_o !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL bp_hold cycle %0d got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                 i, bus.out_valid_o, bus.in_ready_o, bus.data_o, held);
      end
    end
    nxt = {$urandom, $urandom, $urandom, $urandom};
    apply_stimulus(1'b1, 1'b1, nxt, 1'b1);
    n_checks++;
    if (acc !== 1'b1 || fire !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_b2b got acc=%b fire=%b want 1/1", acc, fire); end
    if (fire && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fire_data !== e) begin n_fails++; $display("[TB] FAIL bp_data got %h want %h", fire_data, e); end
    end
    n_checks++;
    if (bus.busy_o !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_no_bubble got busy=%b want 1", bus.busy_o); end
    budget = 0;
    do begin
      apply_stimulus(1'b0, 1'b0, '0, 1'b1);
      budget++;
    end while (!fire && budget < 20);
    n_checks++;
    if (!fire || exp_q.size() == 0) begin n_fails++; $display("[TB] FAIL bp_drain got no output want output"); end
    else begin
      e = exp_q.pop_front();
      if (fire_data !== e) begin n_fails++; $display("[TB] FAIL bp_drain_data got %h want %h", fire_data, e); end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] e;
    int budget = 0;
    apply_stimulus(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.data_o !== 128'h0 || bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL mid_reset got valid=%b ready=%b busy=%b data=%h want 0/1/0/0",
               bus.out_valid_o, bus.in_ready_o, bus.busy_o, bus.data_o);
    end
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    do begin
      apply_stimulus(1'b0, 1'b0, '0, 1'b1);
      budget++;
    end while (!fire && budget < 20);
    n_checks++;
    if (!fire || exp_q.size() != 1) begin n_fails++; $display("[TB] FAIL post_reset got fire=%b queued=%0d want 1/1", fire, exp_q.size()); end
    else begin
      e = exp_q.pop_front();
      n_checks++;
      if (fire_data !== e) begin n_fails++; $display("[TB] FAIL post_reset_data got %h want %h", fire_data, e); end
    end
  endtask

  task automatic test_random();
    logic [127:0] e;
    int sent = 0, recv = 0, cycles = 0, busy_run = 0;
    logic v, rdy;
    while (recv < 1000 && cycles < 60000) begin
      v   = (sent < 1000) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      apply_stimulus(v, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, rdy);
      cycles++;
      if (acc) sent++;
      if (fire) begin
        recv++;
        n_checks++;
        if (exp_q.size() == 0) begin n_fails++; $display("[TB] FAIL rnd_unexpected got %h want nothing", fire_data); end
        else begin
          e = exp_q.pop_front();
          if (fire_data !== e) begin n_fails++; $display("[TB] FAIL rnd_data #%0d got %h want %h", recv, fire_data, e); end
        end
      end
      if (bus.busy_o) busy_run++;
      else if (busy_run != 0) begin
        n_checks++;
        if (busy_run != 4) begin n_fails++; $display("[TB] FAIL rnd_busy_len got %0d want 4", busy_run); end
        busy_run = 0;
      end
    end
    n_checks++;
    if (recv != 1000) begin n_fails++; $display("[TB] FAIL rnd_count got %0d want 1000", recv); end
  endtask

`ifdef AES_MIX_COLUMNS_ITER_CLEAR_EN
  task automatic test_clear();
    apply_stimulus(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (bus.busy_o !== 1'b1 || bus.data_o !== 128'h0) begin
      n_fails++; $display("[TB] FAIL clr_busy_leak got busy=%b data=%h want 1/0", bus.busy_o, bus.data_o);
    end
    clear_s = 1'b1;
    apply_stimulus(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    clear_s = 1'b0;
    exp_q.delete();
    n_checks++;
    if (bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.data_o !== 128'h0) begin
      n_fails++;
      $display("[TB] FAIL clr_idle got ready=%b busy=%b valid=%b data=%h want 1/0/0/0",
               bus.in_ready_o, bus.busy_o, bus.out_valid_o, bus.data_o);
    end
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 1'b0, '0, 1'b1);
      n_checks++;
      if (bus.out_valid_o !== 1'b0 || bus.data_o !== 128'h0) begin
        n_fails++; $display("[TB] FAIL clr_quiet got valid=%b data=%h want 0/0", bus.out_valid_o, bus.data_o);
      end
    end
  endtask
`endif

  initial begin
`ifdef AES_MIX_COLUMNS_ITER_CLEAR_EN
    clear_s = 1'b0;
`endif
    test_reset();
    test_fwd_vector();
    test_inverse();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
`ifdef AES_MIX_COLUMNS_ITER_CLEAR_EN
    test_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
